// File: rtl/accelerator_wb_master_if.sv
// Command/response handshake and classic Wishbone master bus bundle
// for the accelerator Wishbone master.
interface accelerator_wb_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [7:0]  cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic [31:0] wb_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i,
    input  cmd_dat_i, cmd_sel_i, rsp_ready_i,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i,
    output cmd_ready_o, rsp_valid_o,
    output rsp_dat_o, rsp_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_cti_o, wb_bte_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i,
    output cmd_dat_i, cmd_sel_i, rsp_ready_i,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i,
    input  cmd_ready_o, rsp_valid_o,
    input  rsp_dat_o, rsp_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_cti_o, wb_bte_o
  );
endinterface

// File: rtl/accelerator_wb_master.sv
// Single-outstanding classic Wishbone master with retry handling.
// Define ACCEL_WBM_TIMEOUT_EN to abort BUS after TIMEOUT_CYC cycles.
module accelerator_wb_master #(
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                     clk,
  input logic                     wb_rst_i,
  accelerator_wb_master_if.master bus
);
  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE, BUS, RETRY, RESP
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rty_q, rty_d;
  logic          we_q, we_d;
  logic [7:0]    adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          rerr_q, rerr_d;
  logic          cyc_q, rdy_q, vld_q;
  logic          to_hit;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

`ifdef ACCEL_WBM_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] to_q, to_d;

  assign to_hit = (to_q == TO_LAST);

  always_comb begin
    to_d = to_q;
    if (state_d == BUS && state_q != BUS)
      to_d = '0;
    else if (state_q == BUS)
      to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) to_q <= '0;
    else          to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rty_d   = rty_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i && rdy_q) begin
          we_d    = bus.cmd_we_i;
          adr_d   = bus.cmd_adr_i;
          dat_d   = bus.cmd_dat_i;
          sel_d   = bus.cmd_sel_i;
          rty_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // err outranks ack, ack outranks rty
        if (bus.wb_err_i) begin
          rerr_d  = 1'b1;
          rdat_d  = '0;
          state_d = RESP;
        end else if (bus.wb_ack_i) begin
          rerr_d  = 1'b0;
          rdat_d  = we_q ? 32'h0 : bus.wb_dat_i;
          state_d = RESP;
        end else if (bus.wb_rty_i) begin
          if (rty_q < RTY_MAX) begin
            rty_d   = rty_q + 1'b1;
            state_d = RETRY;
          end else begin
            rerr_d  = 1'b1;
            rdat_d  = '0;
            state_d = RESP;
          end
        end else if (to_hit) begin
          rerr_d  = 1'b1;
          rdat_d  = '0;
          state_d = RESP;
        end
      end
      RETRY: state_d = BUS;
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      rty_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
      cyc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rty_q   <= rty_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
      cyc_q   <= (state_d == BUS);
      rdy_q   <= (state_d == IDLE);
      vld_q   <= (state_d == RESP);
    end
  end

  assign bus.cmd_ready_o = rdy_q;
  assign bus.rsp_valid_o = vld_q;
  assign bus.rsp_dat_o   = rdat_q;
  assign bus.rsp_err_o   = rerr_q;
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = cyc_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_o    = dat_q;
  assign bus.wb_sel_o    = sel_q;
  assign bus.wb_cti_o    = 3'b000;
  assign bus.wb_bte_o    = 2'b00;
endmodule

// File: tb/tb_accelerator_wb_master.sv
// Directed bench for accelerator_wb_master with a response
// scoreboard; expected {err,dat} pushed at command issue.
module tb_accelerator_wb_master;
  logic clk = 1'b0;
  logic wb_rst_i = 1'b1;

  int errors = 0;
  int checks = 0;
  logic [32:0] sb[$];

  accelerator_wb_master_if bus ();

  accelerator_wb_master #(
    .MAX_RETRY  (3),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk     (clk),
    .wb_rst_i(wb_rst_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=hang required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic send_cmd(logic we, logic [7:0] adr,
                          logic [31:0] dat, logic [3:0] sel);
    int n = 0;
    while (bus.cmd_ready_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    bus.cmd_valid_i = 1'b1;
    tick();
    bus.cmd_valid_i = 1'b0;
    check("stb_latency",
          32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd3);
    check("wb_adr", 32'(bus.wb_adr_o), 32'(adr));
    check("wb_dat", bus.wb_dat_o, dat);
    check("wb_we_sel", 32'({bus.wb_we_o, bus.wb_sel_o}),
          32'({we, sel}));
  endtask

  task automatic term(logic e, logic a, logic r);
    bus.wb_err_i = e;
    bus.wb_ack_i = a;
    bus.wb_rty_i = r;
    tick();
    bus.wb_err_i = 1'b0;
    bus.wb_ack_i = 1'b0;
    bus.wb_rty_i = 1'b0;
    check("cyc_after_term",
          32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
  endtask

  task automatic get_rsp(int hold);
    logic [32:0] e;
    int n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("rsp_valid_wait", 32'(bus.rsp_valid_o), 32'd1);
    check("sb_pending", 32'(sb.size() > 0), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      check("rsp_hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("rsp_hold_dat", bus.rsp_dat_o, e[31:0]);
      check("rsp_hold_err", 32'(bus.rsp_err_o), 32'(e[32]));
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    check("rsp_dat", bus.rsp_dat_o, e[31:0]);
    check("rsp_err", 32'(bus.rsp_err_o), 32'(e[32]));
    tick();
    bus.rsp_ready_i = 1'b0;
    check("rsp_done_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("idle_ready", 32'(bus.cmd_ready_o), 32'd1);
  endtask

  initial begin
    int drops;
    int seen;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wb_ack_i    = 1'b0;
    bus.wb_err_i    = 1'b0;
    bus.wb_rty_i    = 1'b0;
    bus.wb_dat_i    = '0;

    // reset values
    tick();
    tick();
    check("rst_ctrl", 32'({bus.wb_cyc_o, bus.wb_stb_o,
          bus.wb_we_o, bus.rsp_valid_o, bus.rsp_err_o,
          bus.cmd_ready_o}), 32'd0);
    check("rst_adr", 32'(bus.wb_adr_o), 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    check("rst_sel", 32'(bus.wb_sel_o), 32'd0);
    check("rst_rsp_dat", bus.rsp_dat_o, 32'd0);
    check("cti_bte", 32'({bus.wb_cti_o, bus.wb_bte_o}), 32'd0);
    wb_rst_i = 1'b0;
    tick();
    check("ready_after_rst", 32'(bus.cmd_ready_o), 32'd1);

    // stray ack in IDLE is ignored
    bus.wb_ack_i = 1'b1;
    tick();
    bus.wb_ack_i = 1'b0;
    check("idle_ack_ignored", 32'(bus.rsp_valid_o), 32'd0);

    // write, ack two cycles after strobe
    sb.push_back({1'b0, 32'h0});
    send_cmd(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    tick();
    check("wr_cyc_hold", 32'(bus.wb_cyc_o), 32'd1);
    check("wr_adr_hold", 32'(bus.wb_adr_o), 32'h10);
    check("wr_dat_hold", bus.wb_dat_o, 32'hDEADBEEF);
    term(1'b0, 1'b1, 1'b0);
    get_rsp(0);

    // read, response stalled 3 cycles
    sb.push_back({1'b0, 32'h12345678});
    send_cmd(1'b0, 8'h24, 32'h0, 4'hF);
    bus.wb_dat_i = 32'h12345678;
    term(1'b0, 1'b1, 1'b0);
    bus.wb_dat_i = '0;
    get_rsp(3);

    // two retries then success
    sb.push_back({1'b0, 32'h0BADF00D});
    send_cmd(1'b0, 8'h30, 32'h0, 4'hF);
    repeat (2) begin
      term(1'b0, 1'b0, 1'b1);
      tick();
      check("retry_back_cyc", 32'(bus.wb_cyc_o), 32'd1);
      check("retry_adr", 32'(bus.wb_adr_o), 32'h30);
    end
    bus.wb_dat_i = 32'h0BADF00D;
    term(1'b0, 1'b1, 1'b0);
    bus.wb_dat_i = '0;
    get_rsp(0);

    // retries exhausted on the 4th rty
    sb.push_back({1'b1, 32'h0});
    send_cmd(1'b1, 8'h44, 32'hA5A5A5A5, 4'h3);
    repeat (3) begin
      term(1'b0, 1'b0, 1'b1);
      check("exh_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
      tick();
      check("exh_back_cyc", 32'(bus.wb_cyc_o), 32'd1);
    end
    term(1'b0, 1'b0, 1'b1);
    get_rsp(0);

    // err beats ack; cmd and ack outside their states ignored
    sb.push_back({1'b1, 32'h0});
    send_cmd(1'b0, 8'h58, 32'h0, 4'hF);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_adr_i   = 8'h99;
    tick();
    bus.cmd_valid_i = 1'b0;
    check("busy_not_ready", 32'(bus.cmd_ready_o), 32'd0);
    check("busy_adr_kept", 32'(bus.wb_adr_o), 32'h58);
    check("busy_cyc_kept", 32'(bus.wb_cyc_o), 32'd1);
    bus.wb_dat_i = 32'hFFFF0000;
    term(1'b1, 1'b1, 1'b0);
    bus.wb_ack_i = 1'b1;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    check("resp_ack_no_cyc", 32'(bus.wb_cyc_o), 32'd0);
    get_rsp(1);

`ifdef ACCEL_WBM_TIMEOUT_EN
    sb.push_back({1'b1, 32'h0});
    send_cmd(1'b0, 8'h70, 32'h0, 4'hF);
    repeat (7) tick();
    check("to_cyc_at_7", 32'(bus.wb_cyc_o), 32'd1);
    tick();
    check("to_cyc_at_8", 32'(bus.wb_cyc_o), 32'd0);
    get_rsp(0);
`else
    sb.push_back({1'b0, 32'hCAFE0001});
    send_cmd(1'b0, 8'h70, 32'h0, 4'hF);
    drops = 0;
    repeat (200) begin
      tick();
      if (bus.wb_cyc_o !== 1'b1) drops++;
    end
    check("no_timeout_drops", 32'(drops), 32'd0);
    bus.wb_dat_i = 32'hCAFE0001;
    term(1'b0, 1'b1, 1'b0);
    bus.wb_dat_i = '0;
    get_rsp(0);
`endif

    // reset in 2nd BUS cycle drops the command silently
    send_cmd(1'b1, 8'h80, 32'h11112222, 4'hF);
    tick();
    check("rst_bus2_cyc", 32'(bus.wb_cyc_o), 32'd1);
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    check("rst_mid_cycstb",
          32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
    seen = 0;
    repeat (5) begin
      if (bus.rsp_valid_o !== 1'b0) seen++;
      tick();
    end
    check("rst_no_rsp", 32'(seen), 32'd0);
    sb.push_back({1'b0, 32'h0});
    send_cmd(1'b1, 8'h84, 32'h33334444, 4'hC);
    term(1'b0, 1'b1, 1'b0);
    get_rsp(0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
